// File: rtl/fpu_issue_scheduler.sv
// FPU issue/writeback scheduler: register scoreboard, single-issue register, round-robin writeback arbiter.
// Optional hazard-stall counter built only when SCHED_STATS_EN is defined.
module fpu_issue_scheduler #(
  parameter int ISIZE        = 17,
  parameter int ASIZE        = 5,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             instr_valid,
  input  logic [ISIZE-1:0] instruction,
  output logic             instr_ready,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [1:0]       issue_opcode,
  output logic [ASIZE-1:0] issue_rl,
  output logic [ASIZE-1:0] issue_rr,
  output logic [ASIZE-1:0] issue_rd,
  input  logic [1:0]       wb_req,
  input  logic [ASIZE-1:0] wb_addr0,
  input  logic [ASIZE-1:0] wb_addr1,
  output logic [1:0]       wb_grant,
  output logic             rf_we,
  output logic [ASIZE-1:0] rf_waddr,
  output logic [3:0]       inflight,
  output logic             wb_err,
  output logic [15:0]      stall_cycles
);
  localparam int NREG = 1 << ASIZE;

  logic [NREG-1:0]  busy, busyNext;
  logic [3:0]       inflightQ;
  logic             rrPtr;
  logic [1:0]       decOpcode;
  logic [ASIZE-1:0] decRd, decRl, decRr;
  logic             hazard, full, accept, wbHit, wbMiss;
  logic [1:0]       grantRaw;

  assign decOpcode = instruction[ISIZE-1 -: 2];
  assign decRd     = instruction[3*ASIZE-1 -: ASIZE];
  assign decRl     = instruction[2*ASIZE-1 -: ASIZE];
  assign decRr     = instruction[ASIZE-1:0];

  // Registered busy only: a writeback clearing a register unblocks its readers one cycle later.
  assign hazard      = busy[decRl] | busy[decRr] | busy[decRd];
  assign full        = (inflightQ == 4'(MAX_INFLIGHT));
  assign instr_ready = !hazard && !full && (!issue_valid || issue_ready);
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    grantRaw = 2'b00;
    unique case (wb_req)
      2'b01:   grantRaw = 2'b01;
      2'b10:   grantRaw = 2'b10;
      2'b11:   grantRaw = rrPtr ? 2'b10 : 2'b01;
      default: grantRaw = 2'b00;
    endcase
  end

  // Grant is combinational; gating with reset drops it the moment reset asserts.
  assign wb_grant = reset_n ? grantRaw : 2'b00;
  assign rf_we    = |wb_grant;
  assign rf_waddr = wb_grant[1] ? wb_addr1 : (wb_grant[0] ? wb_addr0 : '0);
  assign wbHit    = rf_we &&  busy[rf_waddr];
  assign wbMiss   = rf_we && !busy[rf_waddr];

  // Set is applied after clear so a coinciding set wins.
  always_comb begin
    busyNext = busy;
    if (wbHit)  busyNext[rf_waddr] = 1'b0;
    if (accept) busyNext[decRd]    = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy         <= '0;
      inflightQ    <= '0;
      rrPtr        <= 1'b0;
      wb_err       <= 1'b0;
      issue_valid  <= 1'b0;
      issue_opcode <= '0;
      issue_rl     <= '0;
      issue_rr     <= '0;
      issue_rd     <= '0;
    end else begin
      busy   <= busyNext;
      wb_err <= wbMiss;
      if (rf_we) rrPtr <= ~rrPtr;
      if (accept && !wbHit && !full)
        inflightQ <= inflightQ + 4'd1;
      else if (!accept && wbHit && inflightQ != 4'd0)
        inflightQ <= inflightQ - 4'd1;
      if (accept) begin
        issue_valid  <= 1'b1;
        issue_opcode <= decOpcode;
        issue_rl     <= decRl;
        issue_rr     <= decRr;
        issue_rd     <= decRd;
      end else if (issue_ready) begin
        issue_valid  <= 1'b0;
      end
    end
  end

  assign inflight = inflightQ;

`ifdef SCHED_STATS_EN
  logic [15:0] stallQ;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      stallQ <= '0;
    else if (instr_valid && !instr_ready && stallQ != 16'hFFFF)
      stallQ <= stallQ + 16'd1;
  end
  assign stall_cycles = stallQ;
`else
  assign stall_cycles = '0;
`endif

endmodule
